// File: rtl/csa_tree_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-save reduction tree:
// operand-count bookkeeping per 3:2 level, level count and register-stage count.
package csa_tree_pkg;

    // Operand count left after 'levels' 3:2 levels, starting from m operands.
    function automatic int csa_ops_after(input int m, input int levels);
        int cnt;
        cnt = m;
        for (int i = 0; i < levels; i++) begin
            cnt = 2 * (cnt / 3) + (cnt % 3);
        end
        return cnt;
    endfunction

    // Number of 3:2 levels needed to bring m operands down to a pair.
    function automatic int csa_level_count(input int m);
        int cnt;
        int lvl;
        cnt = m;
        lvl = 0;
        while (cnt > 2) begin
            cnt = 2 * (cnt / 3) + (cnt % 3);
            lvl++;
        end
        return lvl;
    endfunction

    // Register stage count: one stage per lps levels, but never fewer than one.
    function automatic int csa_lat(input int l, input int lps);
        return (l == 0) ? 1 : (l + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/csa_3to2_level.sv
// One combinational 3:2 reduction level. Operands are taken in groups of three;
// each group becomes a sum word and a left-shifted carry word. The m%3 leftover
// operands pass straight through after the compressed pairs.
module csa_3to2_level
    import csa_tree_pkg::*;
#(
    parameter int W    = 8,
    parameter int M_IN = 3
) (
    input  logic [M_IN*W-1:0]                    in_ops,
    output logic [csa_ops_after(M_IN, 1)*W-1:0] out_ops
);

    localparam int G = M_IN / 3;
    localparam int R = M_IN % 3;

    for (genvar g = 0; g < G; g++) begin : g_fa
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;

        assign a = in_ops[(3*g)*W +: W];
        assign b = in_ops[(3*g+1)*W +: W];
        assign c = in_ops[(3*g+2)*W +: W];

        // The carry out of the top bit is dropped: the true total fits in W bits.
        assign out_ops[(2*g)*W +: W]   = a ^ b ^ c;
        assign out_ops[(2*g+1)*W +: W] = {(a[W-2:0] & b[W-2:0]) |
                                          (a[W-2:0] & c[W-2:0]) |
                                          (b[W-2:0] & c[W-2:0]), 1'b0};
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
        assign out_ops[(2*G+r)*W +: W] = in_ops[(3*G+r)*W +: W];
    end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined, elastic carry-save reduction tree: NUM_IN unsigned N-bit operands
// in, a redundant pair (sum_a, sum_b) out whose sum is the exact total.
// Each register stage holds a valid bit; an empty stage always loads, so
// bubbles collapse and backpressure ripples back to in_ready combinationally.
// Optional: define CSA_TREE_PIPE_SUM_CHECK_EN to carry a reference total down
// the pipe and raise a sticky err when an output pair disagrees with it.
module csa_tree_pipe
    import csa_tree_pkg::*;
#(
    parameter int N                = 64,
    parameter int NUM_IN           = 8,
    parameter int LEVELS_PER_STAGE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_IN*N-1:0]           in_ops,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N+$clog2(NUM_IN)-1:0]   sum_a,
    output logic [N+$clog2(NUM_IN)-1:0]   sum_b,
    output logic                          err
);

    localparam int W   = N + $clog2(NUM_IN);
    localparam int L   = csa_level_count(NUM_IN);
    localparam int LAT = csa_lat(L, LEVELS_PER_STAGE);
    localparam int LPS = LEVELS_PER_STAGE;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        // Levels [FIRST, LAST) sit in front of this stage's registers; the last
        // stage takes whatever levels remain.
        localparam int FIRST = s * LPS;
        localparam int LAST  = ((s == LAT - 1) || ((s + 1) * LPS > L)) ? L : (s + 1) * LPS;
        localparam int NL    = LAST - FIRST;
        localparam int M_IN  = csa_ops_after(NUM_IN, FIRST);
        localparam int M_OUT = csa_ops_after(NUM_IN, LAST);

        logic [M_IN*W-1:0]  stage_in;
        logic [M_OUT*W-1:0] stage_res;
        logic [M_OUT*W-1:0] data_q;
        logic               v_in;
        logic               v_q;
        logic               stage_ready;
`ifdef CSA_TREE_PIPE_SUM_CHECK_EN
        logic [W-1:0]       ref_in;
        logic [W-1:0]       ref_q;
`endif

        if (s == 0) begin : g_head
            for (genvar k = 0; k < NUM_IN; k++) begin : g_zext
                assign stage_in[k*W +: W] = W'(in_ops[k*N +: N]);
            end
            assign v_in = in_valid;
`ifdef CSA_TREE_PIPE_SUM_CHECK_EN
            // Reference total via a plain adder chain over the raw operands.
            always_comb begin
                // NOTE: default first so every path assigns ref_in; no latch.
                ref_in = '0;
                for (int k = 0; k < NUM_IN; k++) begin
                    ref_in = ref_in + W'(in_ops[k*N +: N]);
                end
            end
`endif
        end else begin : g_body
            assign stage_in = g_stage[s-1].data_q;
            assign v_in     = g_stage[s-1].v_q;
`ifdef CSA_TREE_PIPE_SUM_CHECK_EN
            assign ref_in   = g_stage[s-1].ref_q;
`endif
        end

        if (s == LAT - 1) begin : g_tail_rdy
            assign stage_ready = ~v_q | out_ready;
        end else begin : g_mid_rdy
            assign stage_ready = ~v_q | g_stage[s+1].stage_ready;
        end

        if (NL == 0) begin : g_no_lvl
            assign stage_res = stage_in;
        end else begin : g_lvls
            for (genvar j = 0; j < NL; j++) begin : g_lvl
                localparam int MI = csa_ops_after(NUM_IN, FIRST + j);
                localparam int MO = csa_ops_after(NUM_IN, FIRST + j + 1);
                logic [MI*W-1:0] lvl_in;
                logic [MO*W-1:0] lvl_out;

                if (j == 0) begin : g_first
                    assign lvl_in = stage_in;
                end else begin : g_next
                    assign lvl_in = g_lvl[j-1].lvl_out;
                end

                csa_3to2_level #(
                    .W    (W),
                    .M_IN (MI)
                ) u_level (
                    .in_ops  (lvl_in),
                    .out_ops (lvl_out)
                );
            end
            assign stage_res = g_lvl[NL-1].lvl_out;
        end

        // Stage valid: cleared by reset, advances whenever this stage can load.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses <= so every stage samples pre-edge values.
            if (reset) begin
                v_q <= 1'b0;
            end else if (stage_ready) begin
                v_q <= v_in;
            end
        end

        // Stage data: loads only with a valid word so bubbles leave it untouched.
        always_ff @(posedge clk) begin
            // NOTE: data is reset too, so the outputs read zero right after reset.
            if (reset) begin
                data_q <= '0;
            end else if (stage_ready && v_in) begin
                data_q <= stage_res;
            end
        end

`ifdef CSA_TREE_PIPE_SUM_CHECK_EN
        // Reference total travels alongside the data with the same enable.
        always_ff @(posedge clk) begin
            if (reset) begin
                ref_q <= '0;
            end else if (stage_ready && v_in) begin
                ref_q <= ref_in;
            end
        end
`endif
    end

    assign in_ready  = g_stage[0].stage_ready;
    assign out_valid = g_stage[LAT-1].v_q;
    assign sum_a     = g_stage[LAT-1].data_q[W-1:0];
    assign sum_b     = g_stage[LAT-1].data_q[2*W-1:W];

`ifdef CSA_TREE_PIPE_SUM_CHECK_EN
    logic [W-1:0] pair_total;

    assign pair_total = sum_a + sum_b;

    // Sticky mismatch flag, evaluated on every output transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (out_valid && out_ready && (pair_total != g_stage[LAT-1].ref_q)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree: NUM_IN unsigned operands of N bits in, a redundant pair (sum_a, sum_b) out, with sum_a + sum_b equal to the exact total.
- Successor to the fixed 5-to-2 combinational compressor; generalised in operand count, pipeline depth and flow control.
- Sits between the partial-product generator and the final carry-propagate adder in the modular squaring datapath.
- Stages are elastic: bubbles collapse, and backpressure propagates with a valid/ready handshake.

Parameters:
- N, 64, operand width in bits (>=1)
- NUM_IN, 8, number of input operands (>=2)
- LEVELS_PER_STAGE, 1, 3:2 compressor levels between pipeline registers (>=1)
- W (localparam), N+$clog2(NUM_IN), output width
- L (localparam), number of 3:2 levels. Operand count m maps to 2*(m/3) + (m%3) per level, repeated until m==2.
- LAT (localparam), max(1, ceil(L/LEVELS_PER_STAGE)), number of register stages

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand vector valid
- in_ready  out  1  block accepts operands this cycle
- in_ops  in  NUM_IN*N  packed operands; operand k is in_ops[k*N +: N]
- out_valid  out  1  output pair valid
- out_ready  in  1  consumer accepts the pair
- sum_a  out  W  redundant sum, part A
- sum_b  out  W  redundant sum, part B
- err  out  1  sticky self-check error (only with SUM_CHECK_EN; otherwise tied to 0)

Behaviour:
- Reset: one clk with reset=1 clears every stage valid bit. Then out_valid=0, sum_a=0, sum_b=0, err=0, and in_ready=1 in the following cycle. Reset mid-operation discards all in-flight data; no output handshake occurs for it.
- Operands are zero-extended to W before level 0. Each 3:2 level does a bitwise full-add on groups of 3: sum = a^b^c, carry = maj(a,b,c)<<1, truncated to W. Leftover operands (m%3) pass through unchanged.
- Truncation is lossless, because the true total is < NUM_IN*2^N <= 2^W.
- NUM_IN==2 gives L==0: no compressors, a single register stage (LAT=1).
- Register stage s (0..LAT-1) follows level min(L,(s+1)*LEVELS_PER_STAGE)-1. The last stage also absorbs any remaining levels, and its registers drive sum_a/sum_b directly.
- Per stage: valid bit v[s] and data regs. Define ready[s] = !v[s] || ready[s+1], with ready[LAT] = out_ready.
  - Stage s loads when ready[s]=1. The new v[s] is in_valid for s=0, otherwise v[s-1].
  - Data regs load only when the incoming valid is 1. They hold otherwise (no toggling on bubbles).
- in_ready = ready[0]. This is a combinational path from out_ready through all stages, accepted by design.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_valid = v[LAT-1]. sum_a/sum_b stay stable while out_valid && !out_ready.
- Latency: LAT cycles from input transfer to out_valid with no backpressure. Throughput is 1 vector/cycle.
- Full: all v=1 and out_ready=0 gives in_ready=0, and the pipeline holds unchanged.
- Bubble collapse: an empty stage loads even when downstream is stalled.
- Simultaneous output pop and input push when full: everything advances, with no lost or duplicated vector.
- Ordering is strictly FIFO.

Optional Feature:
- Macro: CSA_TREE_PIPE_SUM_CHECK_EN.
- Defined:
  - Each stage also carries a W-bit reference total, computed at stage 0 by a plain adder chain.
  - On every output transfer, err is set if sum_a+sum_b (mod 2^W) != reference. err is sticky until reset.
- Undefined: no reference registers, err tied to 0, no extra logic.

Decomposition:
- Package csa_tree_pkg:
  - function csa_level_count(m) returns L
  - function csa_ops_after(m, levels) returns the operand count after a level
  - function csa_lat(L, lps) returns LAT
- Sub-module csa_3to2_level (params W, M_IN): purely combinational, one reduction level, M_IN operands in, csa_ops_after(M_IN,1) out.
- The top instantiates levels in a generate loop and inserts stage registers at stage boundaries.

Test Plan:
- Reset/idle (N=8, NUM_IN=8, LPS=1, LAT=4): after reset, out_valid=0, sum_a=sum_b=0, in_ready=1, err=0.
- Single vector, ops 1..8, out_ready=1 -> out_valid high exactly 4 cycles after accept; sum_a+sum_b=36.
- Max values: all ops=8'hFF, NUM_IN=8 -> sum_a+sum_b = 2040 = 11'h7F8, W=11, no wrap.
- Backpressure:
  - stream 10 vectors (op k = vector index), out_ready=0 from cycle 2 -> in_ready drops once all 4 stages are full; sum_a/sum_b hold stable.
  - release -> all 10 totals (8*index) appear in order, none lost or duplicated.
- Bubbles and reset:
  - in_valid toggling 1,0,1, out_ready=1 -> output gaps match input gaps.
  - assert reset with 3 vectors in flight -> no out_valid afterwards; the next vector gives the correct total.
- Degenerate configs:
  - NUM_IN=2, N=4: ops 15,15 -> LAT=1, sum=30.
  - NUM_IN=5, LPS=2: L=3, LAT=2; ops 1,2,3,4,5 -> 15 after 2 cycles.
  - With SUM_CHECK_EN, err stays 0 throughout.
